// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch
//   Routes packets from one MAC RX stream to one of NUM_PORTS NIC RX ports.
//   The destination is byte SEL_BYTE of the SOP beat; out-of-range selectors
//   drop the whole packet. A single output register holds one beat, and the
//   data/qualifier bus is shared by all ports with a one-hot valid.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | between packets; waiting for an SOP beat
//   FWD   | forwarding the body of a packet to cur_port
//   DROP  | discarding the body of a packet with an invalid selector
//
// Ports
//   clk, reset                 clock and async active-high reset
//   rx_*_in / rx_ready_out     MAC RX stream (byte 0 = MSB byte of data)
//   nic_*_out / nic_ready_in   shared NIC bus, one-hot nic_valid_out
//   drop_cnt_out               saturating count of dropped packets
//   frame_err_cnt_out          saturating count of framing violations
module eth_rx_dispatch #(
    parameter int NUM_PORTS = 3,
    parameter int SEL_BYTE  = 14,
    parameter int DATA_W    = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    rx_data_in,
    input  logic                 rx_valid_in,
    input  logic                 rx_sop_in,
    input  logic                 rx_eop_in,
    input  logic [4:0]           rx_empty_in,
    input  logic [5:0]           rx_error_in,
    output logic                 rx_ready_out,
    output logic [DATA_W-1:0]    nic_data_out,
    output logic                 nic_sop_out,
    output logic                 nic_eop_out,
    output logic [4:0]           nic_empty_out,
    output logic [5:0]           nic_error_out,
    output logic [NUM_PORTS-1:0] nic_valid_out,
    input  logic [NUM_PORTS-1:0] nic_ready_in,
    output logic [31:0]          drop_cnt_out,
    output logic [15:0]          frame_err_cnt_out
);

    localparam int              PW          = $clog2(NUM_PORTS);
    localparam int              SEL_LSB     = DATA_W - 8 * (SEL_BYTE + 1);
    localparam logic [7:0]      NUM_PORTS_B = 8'(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         cur_port_q, cur_port_d;
    logic                  reg_valid_q, reg_valid_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [4:0]            empty_q, empty_d;
    logic [5:0]            error_q, error_d;
    logic [31:0]           drop_cnt_q, drop_cnt_d;
    logic [15:0]           frame_err_cnt_q, frame_err_cnt_d;

    logic [7:0]            sel;
    logic                  pop;
    logic                  accept;
    logic                  load;
    logic                  fwd_sop;
    logic                  drop_inc;
    logic                  frame_inc;

    assign sel    = rx_data_in[SEL_LSB +: 8];
    assign pop    = reg_valid_q && nic_ready_in[cur_port_q];
    // Gated by reset so the MAC sees backpressure immediately, not at the next edge.
    assign rx_ready_out = !reset && (!reg_valid_q || nic_ready_in[cur_port_q]);
    assign accept = rx_valid_in && rx_ready_out;

    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        load       = 1'b0;
        fwd_sop    = rx_sop_in;
        drop_inc   = 1'b0;
        frame_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_sop_in) begin
                        if (sel < NUM_PORTS_B) begin
                            cur_port_d = sel[PW-1:0];
                            load       = 1'b1;
                            if (!rx_eop_in) state_d = FWD;
                        end else begin
                            drop_inc = 1'b1;
                            if (!rx_eop_in) state_d = DROP;
                        end
                    end else begin
                        frame_inc = 1'b1;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    load      = 1'b1;
                    fwd_sop   = 1'b0;   // stray SOP inside a packet is a continuation beat
                    frame_inc = rx_sop_in;
                    if (rx_eop_in) state_d = IDLE;
                end
            end
            DROP: begin
                if (accept) begin
                    frame_inc = rx_sop_in;
                    if (rx_eop_in) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_valid_d = reg_valid_q;
        if (load)     reg_valid_d = 1'b1;
        else if (pop) reg_valid_d = 1'b0;
        data_d  = load ? rx_data_in  : data_q;
        sop_d   = load ? fwd_sop     : sop_q;
        eop_d   = load ? rx_eop_in   : eop_q;
        empty_d = load ? rx_empty_in : empty_q;
        error_d = load ? rx_error_in : error_q;
        drop_cnt_d      = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + 32'd1 : drop_cnt_q;
        frame_err_cnt_d = (frame_inc && frame_err_cnt_q != '1) ?
                          frame_err_cnt_q + 16'd1 : frame_err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cur_port_q      <= '0;
            reg_valid_q     <= 1'b0;
            data_q          <= '0;
            sop_q           <= 1'b0;
            eop_q           <= 1'b0;
            empty_q         <= '0;
            error_q         <= '0;
            drop_cnt_q      <= '0;
            frame_err_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            cur_port_q      <= cur_port_d;
            reg_valid_q     <= reg_valid_d;
            data_q          <= data_d;
            sop_q           <= sop_d;
            eop_q           <= eop_d;
            empty_q         <= empty_d;
            error_q         <= error_d;
            drop_cnt_q      <= drop_cnt_d;
            frame_err_cnt_q <= frame_err_cnt_d;
        end
    end

    always_comb begin
        nic_valid_out = '0;
        if (reg_valid_q) nic_valid_out[cur_port_q] = 1'b1;
    end

    assign nic_data_out      = data_q;
    assign nic_sop_out       = sop_q;
    assign nic_eop_out       = eop_q;
    assign nic_empty_out     = empty_q;
    assign nic_error_out     = error_q;
    assign drop_cnt_out      = drop_cnt_q;
    assign frame_err_cnt_out = frame_err_cnt_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// tb_eth_rx_dispatch
//   Directed bench for eth_rx_dispatch (NUM_PORTS=3, SEL_BYTE=14, DATA_W=256).
//   Inputs change 1 time unit after posedge; outputs are read after the
//   edge that accepted a beat or on the falling edge.
module tb_eth_rx_dispatch;

    localparam int DW = 256;
    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rx_data_in = '0;
    logic          rx_valid_in = 1'b0;
    logic          rx_sop_in = 1'b0;
    logic          rx_eop_in = 1'b0;
    logic [4:0]    rx_empty_in = '0;
    logic [5:0]    rx_error_in = '0;
    logic          rx_ready_out;
    logic [DW-1:0] nic_data_out;
    logic          nic_sop_out;
    logic          nic_eop_out;
    logic [4:0]    nic_empty_out;
    logic [5:0]    nic_error_out;
    logic [NP-1:0] nic_valid_out;
    logic [NP-1:0] nic_ready_in = '1;
    logic [31:0]   drop_cnt_out;
    logic [15:0]   frame_err_cnt_out;

    eth_rx_dispatch #(.NUM_PORTS(NP), .SEL_BYTE(14), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in), .rx_sop_in(rx_sop_in),
        .rx_eop_in(rx_eop_in), .rx_empty_in(rx_empty_in), .rx_error_in(rx_error_in),
        .rx_ready_out(rx_ready_out),
        .nic_data_out(nic_data_out), .nic_sop_out(nic_sop_out), .nic_eop_out(nic_eop_out),
        .nic_empty_out(nic_empty_out), .nic_error_out(nic_error_out),
        .nic_valid_out(nic_valid_out), .nic_ready_in(nic_ready_in),
        .drop_cnt_out(drop_cnt_out), .frame_err_cnt_out(frame_err_cnt_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int onehot_err = 0;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } rec_t;
    rec_t mq[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat pattern with the selector placed in byte 14 (bits [143:136]).
    function automatic logic [DW-1:0] mk(input logic [7:0] sel, input logic [31:0] tag);
        logic [DW-1:0] d;
        d = {8{tag}};
        d[143:136] = sel;
        return d;
    endfunction

    // Presents one beat and holds it until accepted; w = cycles spent stalled.
    task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop,
                        input logic [4:0] emp, input logic [5:0] err, output int w);
        logic done;
        rx_data_in  = d;
        rx_sop_in   = sop;
        rx_eop_in   = eop;
        rx_empty_in = emp;
        rx_error_in = err;
        rx_valid_in = 1'b1;
        w = 0;
        done = 1'b0;
        while (!done && w < 50) begin
            @(negedge clk);
            if (rx_ready_out) done = 1'b1;
            else w++;
            @(posedge clk);
            #1;
        end
        rx_valid_in = 1'b0;
        if (!done) chk("send_timeout", 256'(done), 256'(1'b1));
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            if ($countones(nic_valid_out) > 1) onehot_err++;
            for (int p = 0; p < NP; p++)
                if (nic_valid_out[p] && nic_ready_in[p])
                    mq.push_back('{port: p, data: nic_data_out, sop: nic_sop_out, eop: nic_eop_out});
        end
    end

    initial begin
        int w;
        int base;
        logic [DW-1:0] a0, a1, a2;
        logic [DW-1:0] bx[4];
        logic [DW-1:0] c1;

        // Reset state
        #12;
        chk("rst_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("rst_ready", 256'(rx_ready_out), 256'(1'b0));
        chk("rst_drop", 256'(drop_cnt_out), 256'(32'd0));
        chk("rst_ferr", 256'(frame_err_cnt_out), 256'(16'd0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", 256'(rx_ready_out), 256'(1'b1));
        @(posedge clk);
        #1;

        // Three-beat packet to port 1, latency 1, pass-through of empty/error
        base = mq.size();
        a0 = mk(8'h01, 32'hA0A0_0001);
        a1 = mk(8'h55, 32'hA1A1_0002);
        a2 = mk(8'h66, 32'hA2A2_0003);
        send(a0, 1'b1, 1'b0, 5'd0, 6'd0, w);
        chk("p1_valid0", 256'(nic_valid_out), 256'(3'b010));
        chk("p1_data0", nic_data_out, a0);
        chk("p1_sop0", 256'(nic_sop_out), 256'(1'b1));
        chk("p1_eop0", 256'(nic_eop_out), 256'(1'b0));
        send(a1, 1'b0, 1'b0, 5'd0, 6'd0, w);
        chk("p1_valid1", 256'(nic_valid_out), 256'(3'b010));
        chk("p1_data1", nic_data_out, a1);
        chk("p1_sop1", 256'(nic_sop_out), 256'(1'b0));
        send(a2, 1'b0, 1'b1, 5'd4, 6'h2A, w);
        chk("p1_valid2", 256'(nic_valid_out), 256'(3'b010));
        chk("p1_data2", nic_data_out, a2);
        chk("p1_eop2", 256'(nic_eop_out), 256'(1'b1));
        chk("p1_empty2", 256'(nic_empty_out), 256'(5'd4));
        chk("p1_err2", 256'(nic_error_out), 256'(6'h2A));
        chk("p1_waits", 256'(w), 256'(0));
        @(posedge clk);
        #1;
        chk("p1_idle_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("p1_count", 256'(mq.size() - base), 256'(3));
        chk("p1_port_last", 256'(mq[base+2].port), 256'(1));

        // Out-of-range selector drops the whole packet
        for (int i = 0; i < 4; i++) begin
            send(mk(8'h07, 32'hD000_0000 + 32'(i)), i == 0, i == 3, 5'd0, 6'd0, w);
            chk("drop_valid", 256'(nic_valid_out), 256'(3'b000));
        end
        chk("drop_cnt1", 256'(drop_cnt_out), 256'(32'd1));
        send(mk(8'h02, 32'h2222_0001), 1'b1, 1'b1, 5'd0, 6'd0, w);
        chk("after_drop_valid", 256'(nic_valid_out), 256'(3'b100));
        chk("after_drop_sop", 256'(nic_sop_out), 256'(1'b1));
        @(posedge clk);
        #1;

        // Port-0 packet with a 5-cycle downstream stall
        base = mq.size();
        for (int i = 0; i < 4; i++) bx[i] = mk(8'h00, 32'hB000_0000 + 32'(i));
        send(bx[0], 1'b1, 1'b0, 5'd0, 6'd0, w);
        chk("bp_valid0", 256'(nic_valid_out), 256'(3'b001));
        nic_ready_in[0] = 1'b0;
        fork
            send(bx[1], 1'b0, 1'b0, 5'd0, 6'd0, w);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_stall_ready", 256'(rx_ready_out), 256'(1'b0));
                    chk("bp_stall_data", nic_data_out, bx[0]);
                    @(posedge clk);
                end
                #1;
                nic_ready_in[0] = 1'b1;
            end
        join
        chk("bp_waits", 256'(w), 256'(5));
        chk("bp_data1", nic_data_out, bx[1]);
        send(bx[2], 1'b0, 1'b0, 5'd0, 6'd0, w);
        send(bx[3], 1'b0, 1'b1, 5'd0, 6'd0, w);
        @(posedge clk);
        #1;
        chk("bp_count", 256'(mq.size() - base), 256'(4));
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", mq[base+i].data, bx[i]);
            chk("bp_port", 256'(mq[base+i].port), 256'(0));
        end

        // Framing errors: stray body beat in IDLE, SOP inside a forwarded packet
        send(mk(8'h00, 32'hE000_0000), 1'b0, 1'b0, 5'd0, 6'd0, w);
        chk("ferr_idle_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("ferr_cnt1", 256'(frame_err_cnt_out), 256'(16'd1));
        send(mk(8'h00, 32'hC000_0000), 1'b1, 1'b0, 5'd0, 6'd0, w);
        c1 = mk(8'h01, 32'hC000_0001);
        send(c1, 1'b1, 1'b0, 5'd0, 6'd0, w);
        chk("ferr_inner_valid", 256'(nic_valid_out), 256'(3'b001));
        chk("ferr_inner_data", nic_data_out, c1);
        chk("ferr_inner_sop", 256'(nic_sop_out), 256'(1'b0));
        send(mk(8'h00, 32'hC000_0002), 1'b0, 1'b1, 5'd0, 6'd0, w);
        chk("ferr_cnt2", 256'(frame_err_cnt_out), 256'(16'd2));
        chk("ferr_drop_same", 256'(drop_cnt_out), 256'(32'd1));

        // Single-beat packet back-to-back with a two-beat port-2 packet
        send(mk(8'h00, 32'h5000_0000), 1'b1, 1'b1, 5'd0, 6'd0, w);
        chk("b2b_valid0", 256'(nic_valid_out), 256'(3'b001));
        chk("b2b_eop0", 256'(nic_eop_out), 256'(1'b1));
        chk("b2b_wait0", 256'(w), 256'(0));
        send(mk(8'h02, 32'h5000_0001), 1'b1, 1'b0, 5'd0, 6'd0, w);
        chk("b2b_valid1", 256'(nic_valid_out), 256'(3'b100));
        chk("b2b_wait1", 256'(w), 256'(0));
        send(mk(8'h33, 32'h5000_0002), 1'b0, 1'b1, 5'd0, 6'd0, w);
        chk("b2b_valid2", 256'(nic_valid_out), 256'(3'b100));
        chk("b2b_eop2", 256'(nic_eop_out), 256'(1'b1));
        chk("b2b_wait2", 256'(w), 256'(0));

        // Dropped single-beat packet, then dropped packet with a stray SOP inside
        send(mk(8'h09, 32'h6000_0000), 1'b1, 1'b1, 5'd0, 6'd0, w);
        chk("drop1_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("drop_cnt2", 256'(drop_cnt_out), 256'(32'd2));
        send(mk(8'h05, 32'h6000_0001), 1'b1, 1'b0, 5'd0, 6'd0, w);
        send(mk(8'h00, 32'h6000_0002), 1'b1, 1'b0, 5'd0, 6'd0, w);
        chk("drop_inner_valid", 256'(nic_valid_out), 256'(3'b000));
        send(mk(8'h00, 32'h6000_0003), 1'b0, 1'b1, 5'd0, 6'd0, w);
        chk("drop_cnt3", 256'(drop_cnt_out), 256'(32'd3));
        chk("ferr_cnt3", 256'(frame_err_cnt_out), 256'(16'd3));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a forwarded packet
        send(mk(8'h01, 32'h7000_0000), 1'b1, 1'b0, 5'd0, 6'd0, w);
        chk("mid_valid", 256'(nic_valid_out), 256'(3'b010));
        nic_ready_in[1] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 256'(nic_valid_out), 256'(3'b000));
        chk("arst_ready", 256'(rx_ready_out), 256'(1'b0));
        chk("arst_drop", 256'(drop_cnt_out), 256'(32'd0));
        chk("arst_ferr", 256'(frame_err_cnt_out), 256'(16'd0));
        @(negedge clk);
        reset = 1'b0;
        nic_ready_in = '1;
        @(posedge clk);
        #1;
        base = mq.size();
        send(mk(8'h02, 32'h7000_0001), 1'b1, 1'b1, 5'd0, 6'd0, w);
        chk("post_rst_valid", 256'(nic_valid_out), 256'(3'b100));
        chk("post_rst_sop", 256'(nic_sop_out), 256'(1'b1));
        @(posedge clk);
        #1;
        chk("post_rst_count", 256'(mq.size() - base), 256'(1));
        chk("post_rst_port", 256'(mq[base].port), 256'(2));

        chk("onehot", 256'(onehot_err), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_rx_dispatch.md
ETH_RX_DISPATCH -- requirements
Module: eth_rx_dispatch

Interface
REQ-001: Parameter NUM_PORTS, default 3, SHALL set the number of downstream NIC RX ports (2..8).
REQ-002: Parameter SEL_BYTE, default 14, SHALL set the byte index within the SOP beat that selects the destination port.
REQ-003: Parameter DATA_W, default 256, SHALL set the stream data width in bits.
REQ-004: clk  in  1  single clock for all logic (the Ethernet RX clock).
REQ-005: reset  in  1  asynchronous, active-high reset.
REQ-006: rx_data_in  in  DATA_W  MAC RX beat data; byte 0 = bits [DATA_W-1:DATA_W-8].
REQ-007: rx_valid_in, rx_sop_in, rx_eop_in  in  1 each  MAC beat qualifiers.
REQ-008: rx_empty_in  in  5  empty bytes on the EOP beat.
REQ-009: rx_error_in  in  6  MAC error flags.
REQ-010: rx_ready_out  out  1  backpressure to the MAC.
REQ-011: nic_data_out  out  DATA_W  shared data bus to all ports.
REQ-012: nic_sop_out, nic_eop_out  out  1 each  shared qualifiers.
REQ-013: nic_empty_out  out  5  shared empty field.
REQ-014: nic_error_out  out  6  shared error field.
REQ-015: nic_valid_out  out  NUM_PORTS  one-hot per-port valid.
REQ-016: nic_ready_in  in  NUM_PORTS  per-port ready.
REQ-017: drop_cnt_out  out  32  saturating count of dropped packets.
REQ-018: frame_err_cnt_out  out  16  saturating count of framing violations.

Function
REQ-019: Beat acceptance SHALL occur when rx_valid_in and rx_ready_out are both 1.
REQ-020: A single output register SHALL hold one beat; rx_ready_out = !reg_valid || nic_ready_in[cur_port].
REQ-021: Latency from accepted input beat to nic_valid_out assertion SHALL be exactly 1 cycle.
REQ-022: An output beat SHALL complete when nic_valid_out[cur_port] and nic_ready_in[cur_port] are both 1; data is held stable otherwise.
REQ-023: The FSM SHALL have states IDLE, FWD, and DROP; reset state is IDLE.
REQ-024: IDLE, accepted beat with sop=1: sel = byte SEL_BYTE; if sel < NUM_PORTS, latch cur_port=sel, register the beat, and go to FWD; otherwise discard the beat, increment drop_cnt, and go to DROP.
REQ-025: SOP beat with eop=1 (single-beat packet) SHALL be handled as in REQ-024 but remain in IDLE.
REQ-026: IDLE, accepted beat with sop=0: the beat SHALL be discarded, frame_err_cnt incremented, and the state stays IDLE.
REQ-027: FWD: every accepted beat SHALL be registered to cur_port; eop=1 returns the FSM to IDLE.
REQ-028: DROP: accepted beats SHALL be discarded; eop=1 returns the FSM to IDLE.
REQ-029: In FWD or DROP, an accepted beat with sop=1 SHALL be treated as a continuation beat (forwarded with sop cleared, or dropped) and SHALL increment frame_err_cnt.
REQ-030: rx_error_in and rx_empty_in SHALL pass through unmodified with the beat; error never causes a drop.
REQ-031: cur_port SHALL change only on an accepted SOP beat in IDLE.
REQ-032: In DROP and in IDLE, rx_ready_out SHALL be 1 whenever no registered beat is pending.
REQ-033: Counters SHALL saturate at all-ones and never wrap.
REQ-034: If a drop and a frame error occur in the same cycle, each counter SHALL increment independently.
REQ-035: At most one bit of nic_valid_out SHALL be 1 in any cycle.

Reset
REQ-036: On assertion of reset, the following SHALL clear immediately without waiting for clk: state=IDLE, reg_valid=0, nic_valid_out=0, cur_port=0, both counters=0, rx_ready_out=0.
REQ-037: After reset deasserts, rx_ready_out SHALL be 1 on the first clk edge.
REQ-038: A packet in flight at reset SHALL be abandoned, with no EOP emitted.

Verification
REQ-039: SOP beat with byte14=0x01 followed by 2 more beats, last with eop=1, empty=4 -> 3 beats on port 1, each 1 cycle after input; sop on the first, eop+empty=4 on the last; ports 0 and 2 see no valid.
REQ-040: SOP with byte14=0x07 (NUM_PORTS=3), 4-beat packet -> no nic_valid_out; drop_cnt=1; next SOP with byte14=0x02 routes to port 2.
REQ-041: Port 0 packet with nic_ready_in[0] low for 5 cycles mid-packet -> rx_ready_out low for those cycles, output data stable, no beat lost or duplicated.
REQ-042: Non-SOP beat in IDLE, then a SOP beat inside a FWD packet -> frame_err_cnt=2; the inner beat is forwarded with sop=0.
REQ-043: Single-beat packet (sop=eop=1, byte14=0x00) back-to-back with a 2-beat port-2 packet -> correct routing, zero bubble cycles with all readies held at 1.
REQ-044: Reset asserted mid-FWD -> nic_valid_out drops to 0 asynchronously, counters read 0, and the next SOP routes normally.
